// File: rtl/pwm_multi_gen.sv
// rtl/pwm_multi_gen.sv - multi-channel PWM generator with shared prescaled timebase
// Shadow compare/function/period registers commit to active copies on period boundaries.
module pwm_multi_gen #(
    parameter int CH = 4,
    parameter int CW = 16,
    parameter int PW = 8,
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           count_reset,
    input  logic [1:0]     mode,
    input  logic [PW-1:0]  prescale,
    input  logic [CW-1:0]  period,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [1:0]     cfg_sel,
    input  logic [CW-1:0]  cfg_data,
    input  logic [CH-1:0]  pwm_en,
    output logic [CW-1:0]  count_val,
    output logic           update_evt,
    output logic [CH-1:0]  pwm_out
);
    localparam logic [1:0] M_DOWN   = 2'b01;
    localparam logic [1:0] M_CENTRE = 2'b10;

    logic [PW-1:0] presc;
    logic          dir;
    logic          tick;
    logic          boundary;
    logic          dir_next;
    logic          commit;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] act_period;
    logic [1:0]    eff_mode;
    logic [CH-1:0] pwm_next;

    logic [CW-1:0] sh_cmp1  [CH];
    logic [CW-1:0] sh_cmp2  [CH];
    logic [1:0]    sh_func  [CH];
    logic [CW-1:0] act_cmp1 [CH];
    logic [CW-1:0] act_cmp2 [CH];
    logic [1:0]    act_func [CH];

    assign eff_mode = (mode == 2'b11) ? 2'b00 : mode;
    assign tick     = en && (presc >= prescale);
    // While the timebase is stopped the actives simply follow the shadows.
    assign commit   = count_reset || !en || (tick && boundary);

    always_comb begin
        cnt_next = count_val;
        dir_next = dir;
        boundary = 1'b0;
        case (eff_mode)
            M_DOWN: begin
                if (count_val == '0) begin
                    cnt_next = period;
                    boundary = 1'b1;
                end else begin
                    cnt_next = count_val - CW'(1);
                end
            end
            M_CENTRE: begin
                if (act_period == '0) begin
                    cnt_next = '0;
                    dir_next = 1'b0;
                    boundary = 1'b1;
                end else if (!dir) begin
                    if (count_val >= act_period) begin
                        dir_next = 1'b1;
                        cnt_next = count_val - CW'(1);
                    end else begin
                        cnt_next = count_val + CW'(1);
                    end
                end else if (count_val == '0) begin
                    // Valley: leaving 0 upward is the period boundary
                    dir_next = 1'b0;
                    cnt_next = (period == '0) ? '0 : CW'(1);
                    boundary = 1'b1;
                end else begin
                    cnt_next = count_val - CW'(1);
                end
            end
            default: begin
                if (count_val >= act_period) begin
                    cnt_next = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_next = count_val + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            dir        <= 1'b0;
            count_val  <= '0;
            update_evt <= 1'b0;
        end else begin
            update_evt <= 1'b0;
            if (count_reset) begin
                presc     <= '0;
                dir       <= 1'b0;
                count_val <= (eff_mode == M_DOWN) ? period : '0;
            end else if (en) begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    count_val  <= cnt_next;
                    dir        <= dir_next;
                    update_evt <= boundary;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                sh_cmp1[i] <= '0;
                sh_cmp2[i] <= '0;
                sh_func[i] <= '0;
            end
        end else if (cfg_we && (int'(cfg_ch) < CH)) begin
            case (cfg_sel)
                2'd0:    sh_cmp1[cfg_ch] <= cfg_data;
                2'd1:    sh_cmp2[cfg_ch] <= cfg_data;
                2'd2:    sh_func[cfg_ch] <= cfg_data[1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_period <= '0;
            for (int i = 0; i < CH; i++) begin
                act_cmp1[i] <= '0;
                act_cmp2[i] <= '0;
                act_func[i] <= '0;
            end
        end else if (commit) begin
            act_period <= period;
            for (int i = 0; i < CH; i++) begin
                act_cmp1[i] <= sh_cmp1[i];
                act_cmp2[i] <= sh_cmp2[i];
                act_func[i] <= sh_func[i];
            end
        end
    end

    always_comb begin
        pwm_next = '0;
        for (int i = 0; i < CH; i++) begin
            case (act_func[i])
                2'b00:   pwm_next[i] = count_val < act_cmp1[i];
                2'b01:   pwm_next[i] = count_val >= act_cmp1[i];
                2'b10:   pwm_next[i] = (act_cmp1[i] < act_cmp2[i]) &&
                                       (count_val >= act_cmp1[i]) &&
                                       (count_val < act_cmp2[i]);
                default: pwm_next[i] = 1'b0;
            endcase
            pwm_next[i] = pwm_next[i] & pwm_en[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= pwm_next;
        end
    end
endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb/tb_pwm_multi_gen.sv - scoreboard bench for pwm_multi_gen
module tb_pwm_multi_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        count_reset;
    logic [1:0]  mode;
    logic [7:0]  prescale;
    logic [15:0] period;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_data;
    logic [4:0]  pwm_en;
    logic [15:0] count_val;
    logic        update_evt;
    logic [4:0]  pwm_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] cnt;
        logic        evt;
        logic [4:0]  pwm;
    } exp_t;
    exp_t sb[$];

    pwm_multi_gen #(.CH(5), .CW(16), .PW(8)) dut (
        .clk(clk), .rst(rst), .en(en), .count_reset(count_reset), .mode(mode),
        .prescale(prescale), .period(period), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .pwm_en(pwm_en),
        .count_val(count_val), .update_evt(update_evt), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] c, input logic e, input logic [4:0] p);
        exp_t x;
        x.cnt = c;
        x.evt = e;
        x.pwm = p;
        sb.push_back(x);
    endtask

    task automatic cycle(input string tag, input int idx);
        exp_t x;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s[%0d] scoreboard underflow observed=%0d expected=entry", tag, idx, count_val);
        end else begin
            x = sb.pop_front();
            check($sformatf("%s[%0d].count_val", tag, idx), 32'(count_val), 32'(x.cnt));
            check($sformatf("%s[%0d].update_evt", tag, idx), 32'(update_evt), 32'(x.evt));
            check($sformatf("%s[%0d].pwm_out", tag, idx), 32'(pwm_out), 32'(x.pwm));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int ch, input int sel, input int data);
        cfg_we   = 1'b1;
        cfg_ch   = 3'(ch);
        cfg_sel  = 2'(sel);
        cfg_data = 16'(data);
        idle(1);
        cfg_we   = 1'b0;
    endtask

    task automatic restart();
        count_reset = 1'b1;
        idle(1);
        count_reset = 1'b0;
    endtask

    initial begin
        int s[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
        int prev;
        int c;
        int m;
        logic e;

        rst = 1'b1; en = 1'b0; count_reset = 1'b0; mode = 2'b00; prescale = 8'd0;
        period = 16'd0; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_sel = 2'd0; cfg_data = 16'd0;
        pwm_en = 5'b00000;
        idle(2);
        check("reset.count_val", 32'(count_val), 32'd0);
        check("reset.update_evt", 32'(update_evt), 32'd0);
        check("reset.pwm_out", 32'(pwm_out), 32'd0);
        rst = 1'b0;

        // T1 + T3: up count P=9, ch0 left-aligned, cmp1 changes mid-period and on a boundary
        period = 16'd9; pwm_en = 5'b11111;
        cfg_write(0, 0, 3);
        idle(2);
        en = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            int a;
            a = (k <= 40) ? 3 : ((k <= 60) ? 7 : 2);
            push(16'(k % 10), (k % 10) == 0, {4'b0, ((k - 1) % 10) < a});
        end
        for (int k = 1; k <= 70; k++) begin
            if (k == 33 || k == 50) begin
                cfg_we = 1'b1; cfg_ch = 3'd0; cfg_sel = 2'd0;
                cfg_data = (k == 33) ? 16'd7 : 16'd2;
            end
            cycle("t1", k);
            cfg_we = 1'b0;
        end

        // T2: centre-aligned P=4, prescale=1, ch1 range 1..3
        en = 1'b0; mode = 2'b10; prescale = 8'd1; period = 16'd4; pwm_en = 5'b00010;
        cfg_write(1, 0, 1);
        cfg_write(1, 1, 3);
        cfg_write(1, 2, 2);
        idle(2);
        restart();
        en = 1'b1;
        prev = 0;
        for (int k = 1; k <= 40; k++) begin
            c = s[(k / 2) % 8];
            e = (k % 2 == 0) && ((k / 2) % 8 == 1) && (k / 2 > 1);
            push(16'(c), e, {3'b0, (prev >= 1 && prev < 3), 1'b0});
            prev = c;
        end
        for (int k = 1; k <= 40; k++) cycle("t2", k);

        // T4: down count P=5, prescale=1, ch2 right-aligned, count_reset mid-count
        en = 1'b0; mode = 2'b01; prescale = 8'd1; period = 16'd5; pwm_en = 5'b00100;
        cfg_write(2, 0, 2);
        cfg_write(2, 2, 1);
        idle(2);
        restart();
        check("t4.count_reset_load", 32'(count_val), 32'd5);
        en = 1'b1;
        prev = 5;
        for (int k = 1; k <= 36; k++) begin
            if (k <= 6) begin
                c = 5 - ((k / 2) % 6);
                e = 1'b0;
            end else if (k == 7) begin
                c = 5;
                e = 1'b0;
            end else begin
                m = k - 7;
                c = 5 - ((m / 2) % 6);
                e = (m % 2 == 0) && ((m / 2) % 6 == 0);
            end
            push(16'(c), e, {2'b0, prev >= 2, 2'b0});
            prev = c;
        end
        for (int k = 1; k <= 36; k++) begin
            if (k == 7) count_reset = 1'b1;
            cycle("t4", k);
            count_reset = 1'b0;
        end

        // T5: P=0, equal range bounds, out-of-range channel, pwm_en masking
        en = 1'b0; mode = 2'b00; prescale = 8'd0; period = 16'd0; pwm_en = 5'b01011;
        cfg_write(3, 0, 5);
        cfg_write(3, 1, 5);
        cfg_write(3, 2, 2);
        idle(2);
        restart();
        en = 1'b1;
        for (int k = 1; k <= 11; k++) push(16'd0, 1'b1, (k == 9) ? 5'b01001 : 5'b00001);
        for (int k = 1; k <= 11; k++) begin
            if (k == 4) begin
                cfg_we = 1'b1; cfg_ch = 3'd5; cfg_sel = 2'd2; cfg_data = 16'd0;
            end
            if (k == 7) begin
                cfg_we = 1'b1; cfg_ch = 3'd3; cfg_sel = 2'd2; cfg_data = 16'd0;
            end
            if (k == 10) pwm_en = 5'b00011;
            cycle("t5", k);
            cfg_we = 1'b0;
        end

        // T6: asynchronous reset mid-run, restart with en held high
        period = 16'd9; pwm_en = 5'b11111;
        idle(4);
        check("t6.pre_reset_count", 32'(count_val), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("t6.async_count_val", 32'(count_val), 32'd0);
        check("t6.async_update_evt", 32'(update_evt), 32'd0);
        check("t6.async_pwm_out", 32'(pwm_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 1) push(16'd0, 1'b1, 5'b00000);
            else push(16'((k - 1) % 10), ((k - 1) % 10) == 0, 5'b00000);
        end
        for (int k = 1; k <= 15; k++) cycle("t6", k);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
